// File: rtl/nf_hazard_unit_pm_if.sv
// Bundles the hazard unit's pipeline-side signals; slave = hazard unit, master = core datapath.
// The NF_HU_PERF_CNT_EN macro adds the stall counter signals.
interface nf_hazard_unit_pm_if #(
  parameter int RD_PORTS = 2,
  parameter int N_FWD    = 2,
  parameter int RA_W     = 5
);
  localparam int FWD_SEL_W = $clog2(N_FWD + 1);

  logic [N_FWD*RA_W-1:0]         wa_fwd;
  logic [N_FWD-1:0]              we_fwd;
  logic [RD_PORTS*RA_W-1:0]      ra_exe;
  logic [RD_PORTS*RA_W-1:0]      ra_id;
  logic [RA_W-1:0]               wa_exe;
  logic                          we_rf_exe;
  logic                          rf_src_exe;
  logic                          branch_id;
  logic                          req_dm_mem;
  logic                          req_ack_dm;
  logic                          req_ack_i;
  logic                          err_clr;
  logic [RD_PORTS*FWD_SEL_W-1:0] rd_bypass;
  logic [RD_PORTS-1:0]           cmp_bypass;
  logic                          stall_if;
  logic                          stall_id;
  logic                          stall_exe;
  logic                          stall_mem;
  logic                          stall_wb;
  logic                          flush_exe;
  logic                          dm_busy;
  logic                          dm_err;
`ifdef NF_HU_PERF_CNT_EN
  logic                          stall_cnt_clr;
  logic [31:0]                   stall_cnt;
`endif

  modport slave (
`ifdef NF_HU_PERF_CNT_EN
    input  stall_cnt_clr,
    output stall_cnt,
`endif
    input  wa_fwd, we_fwd, ra_exe, ra_id, wa_exe, we_rf_exe, rf_src_exe,
           branch_id, req_dm_mem, req_ack_dm, req_ack_i, err_clr,
    output rd_bypass, cmp_bypass, stall_if, stall_id, stall_exe, stall_mem,
           stall_wb, flush_exe, dm_busy, dm_err
  );

  modport master (
`ifdef NF_HU_PERF_CNT_EN
    output stall_cnt_clr,
    input  stall_cnt,
`endif
    output wa_fwd, we_fwd, ra_exe, ra_id, wa_exe, we_rf_exe, rf_src_exe,
           branch_id, req_dm_mem, req_ack_dm, req_ack_i, err_clr,
    input  rd_bypass, cmp_bypass, stall_if, stall_id, stall_exe, stall_mem,
           stall_wb, flush_exe, dm_busy, dm_err
  );
endinterface

// File: rtl/nf_hazard_unit_pm.sv
// nanoFOX hazard unit: N-stage forwarding, load-use/branch stalls, data-memory wait FSM with timeout.
// Define NF_HU_PERF_CNT_EN to add the stall_if cycle counter.
module nf_hazard_unit_pm #(
  parameter int RD_PORTS   = 2,
  parameter int N_FWD      = 2,
  parameter int RA_W       = 5,
  parameter int DM_TIMEOUT = 256
) (
  input logic               clk,
  input logic               rst,
  nf_hazard_unit_pm_if.slave hu
);
  localparam int FWD_SEL_W = $clog2(N_FWD + 1);
  localparam int CNT_W     = $clog2(DM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DM_TIMEOUT - 1);

  typedef enum logic {DM_IDLE, DM_WAIT} dm_state_t;

  dm_state_t                     state;
  dm_state_t                     state_next;
  logic [CNT_W-1:0]              wait_cnt;
  logic [CNT_W-1:0]              wait_cnt_next;
  logic                          err_set;
  logic                          err_q;
  logic [RD_PORTS*FWD_SEL_W-1:0] rd_bypass_c;
  logic [RD_PORTS-1:0]           cmp_bypass_c;
  logic                          id_uses_exe;
  logic                          load_use;
  logic                          branch_stall;
  logic                          if_stall;
  logic                          dm_stall;

  // Scanning from the farthest stage down lets the nearest matching producer win.
  always_comb begin
    rd_bypass_c  = '0;
    cmp_bypass_c = '0;
    id_uses_exe  = 1'b0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int k = N_FWD - 1; k >= 0; k--) begin
        if (hu.we_fwd[k] && (hu.wa_fwd[k*RA_W +: RA_W] == hu.ra_exe[p*RA_W +: RA_W]) &&
            (hu.ra_exe[p*RA_W +: RA_W] != '0))
          rd_bypass_c[p*FWD_SEL_W +: FWD_SEL_W] = FWD_SEL_W'(k + 1);
      end
      cmp_bypass_c[p] = hu.we_fwd[0] && (hu.wa_fwd[0 +: RA_W] == hu.ra_id[p*RA_W +: RA_W]) &&
                        (hu.ra_id[p*RA_W +: RA_W] != '0);
      if (hu.ra_id[p*RA_W +: RA_W] == hu.wa_exe)
        id_uses_exe = 1'b1;
    end
  end

  assign load_use     = hu.we_rf_exe && hu.rf_src_exe && (hu.wa_exe != '0) && id_uses_exe;
  assign branch_stall = hu.branch_id && hu.we_rf_exe && (hu.wa_exe != '0) && id_uses_exe;
  assign if_stall     = ~hu.req_ack_i;
  assign dm_stall     = hu.req_dm_mem && ~hu.req_ack_dm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DM_IDLE;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (err_set)
        err_q <= 1'b1;
      else if (hu.err_clr)
        err_q <= 1'b0;
    end
  end

  // Leaving DM_WAIT on ack or dropped request; the counter only runs while waiting.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_set       = 1'b0;
    case (state)
      DM_IDLE: begin
        if (dm_stall)
          state_next = DM_WAIT;
      end
      DM_WAIT: begin
        if (!dm_stall)
          state_next = DM_IDLE;
        else if (wait_cnt != CNT_MAX)
          wait_cnt_next = wait_cnt + 1'b1;
        err_set = dm_stall && (wait_cnt == CNT_MAX);
      end
      default: state_next = DM_IDLE;
    endcase
    if (state_next == DM_IDLE)
      wait_cnt_next = '0;
  end

  assign hu.rd_bypass  = rd_bypass_c;
  assign hu.cmp_bypass = cmp_bypass_c;
  assign hu.stall_if   = load_use | branch_stall | if_stall | dm_stall;
  assign hu.stall_id   = load_use | branch_stall | if_stall | dm_stall;
  assign hu.stall_exe  = dm_stall;
  assign hu.stall_mem  = dm_stall;
  assign hu.stall_wb   = dm_stall;
  assign hu.flush_exe  = (load_use | branch_stall | if_stall) & ~dm_stall;
  assign hu.dm_busy    = (state == DM_WAIT);
  assign hu.dm_err     = err_q;

`ifdef NF_HU_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (hu.stall_cnt_clr)
      stall_cnt_q <= '0;
    else if (hu.stall_if)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign hu.stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_nf_hazard_unit_pm.sv
// Self-checking bench for nf_hazard_unit_pm: directed plan steps, then random traffic against a cycle-count model.
// Covers the stall counter too when NF_HU_PERF_CNT_EN is defined.
module tb_nf_hazard_unit_pm;
  localparam int RD = 2;
  localparam int NF = 2;
  localparam int AW = 5;
  localparam int TO = 4;
  localparam int SW = $clog2(NF + 1);

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  // Model state: cycles the data-memory stall has been pending, sticky error, stall counter.
  int          pend;
  bit          err_m;
  logic [31:0] cnt_m;

  nf_hazard_unit_pm_if #(.RD_PORTS(RD), .N_FWD(NF), .RA_W(AW)) bus ();

  nf_hazard_unit_pm #(.RD_PORTS(RD), .N_FWD(NF), .RA_W(AW), .DM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .hu  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit id_reads_exe_dest();
    for (int p = 0; p < RD; p++)
      if (bus.ra_id[p*AW +: AW] == bus.wa_exe) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_pipe_hazard();
    bit dep;
    dep = bus.we_rf_exe && (bus.wa_exe != 0) && id_reads_exe_dest();
    return (dep && bus.rf_src_exe) || (dep && bus.branch_id) || !bus.req_ack_i;
  endfunction

  function automatic bit exp_dm_stall();
    return bus.req_dm_mem && !bus.req_ack_dm;
  endfunction

  task automatic check_output();
    logic [RD*SW-1:0] eb;
    logic [RD-1:0]    ec;
    logic [AW-1:0]    ra;
    bit               hz;
    bit               dms;
    eb = '0;
    ec = '0;
    for (int p = 0; p < RD; p++) begin
      ra = bus.ra_exe[p*AW +: AW];
      for (int k = 0; k < NF; k++) begin
        if (bus.we_fwd[k] && bus.wa_fwd[k*AW +: AW] == ra && ra != 0) begin
          eb[p*SW +: SW] = SW'(k + 1);
          break;
        end
      end
      ec[p] = bus.we_fwd[0] && bus.wa_fwd[0 +: AW] == bus.ra_id[p*AW +: AW] &&
              bus.ra_id[p*AW +: AW] != 0;
    end
    hz  = exp_pipe_hazard();
    dms = exp_dm_stall();
    cmp("rd_bypass", 64'(bus.rd_bypass), 64'(eb));
    cmp("cmp_bypass", 64'(bus.cmp_bypass), 64'(ec));
    cmp("stall_if", 64'(bus.stall_if), 64'(hz | dms));
    cmp("stall_id", 64'(bus.stall_id), 64'(hz | dms));
    cmp("stall_exe", 64'(bus.stall_exe), 64'(dms));
    cmp("stall_mem", 64'(bus.stall_mem), 64'(dms));
    cmp("stall_wb", 64'(bus.stall_wb), 64'(dms));
    cmp("flush_exe", 64'(bus.flush_exe), 64'(hz & !dms));
    cmp("dm_busy", 64'(bus.dm_busy), 64'(pend > 0));
    cmp("dm_err", 64'(bus.dm_err), 64'(err_m));
`ifdef NF_HU_PERF_CNT_EN
    cmp("stall_cnt", 64'(bus.stall_cnt), 64'(cnt_m));
`endif
  endtask

  task automatic model_edge();
    bit dms;
    bit sif;
    if (rst) begin
      pend  = 0;
      err_m = 1'b0;
      cnt_m = '0;
    end else begin
      dms = exp_dm_stall();
      sif = exp_pipe_hazard() | dms;
      if (dms && pend >= TO) err_m = 1'b1;
      else if (bus.err_clr) err_m = 1'b0;
      pend = dms ? pend + 1 : 0;
`ifdef NF_HU_PERF_CNT_EN
      if (bus.stall_cnt_clr) cnt_m = '0;
      else if (sif) cnt_m = cnt_m + 32'd1;
`else
      if (sif) cnt_m = cnt_m + 32'd1;
`endif
    end
  endtask

  // One cycle: check at negedge+1, advance model on the active edge, return to negedge.
  task automatic tick();
    #1 check_output();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_stimulus();
    bus.wa_fwd     = '0;
    bus.we_fwd     = '0;
    bus.ra_exe     = '0;
    bus.ra_id      = '0;
    bus.wa_exe     = '0;
    bus.we_rf_exe  = 1'b0;
    bus.rf_src_exe = 1'b0;
    bus.branch_id  = 1'b0;
    bus.req_dm_mem = 1'b0;
    bus.req_ack_dm = 1'b0;
    bus.req_ack_i  = 1'b1;
    bus.err_clr    = 1'b0;
`ifdef NF_HU_PERF_CNT_EN
    bus.stall_cnt_clr = 1'b0;
`endif
  endtask

  task automatic apply_random();
    for (int k = 0; k < NF; k++) bus.wa_fwd[k*AW +: AW] = AW'($urandom_range(0, 3));
    for (int p = 0; p < RD; p++) begin
      bus.ra_exe[p*AW +: AW] = AW'($urandom_range(0, 3));
      bus.ra_id[p*AW +: AW]  = AW'($urandom_range(0, 3));
    end
    bus.we_fwd     = NF'($urandom);
    bus.wa_exe     = AW'($urandom_range(0, 3));
    bus.we_rf_exe  = $urandom_range(0, 1) == 1;
    bus.rf_src_exe = $urandom_range(0, 1) == 1;
    bus.branch_id  = $urandom_range(0, 3) == 0;
    bus.req_dm_mem = $urandom_range(0, 3) != 0;
    bus.req_ack_dm = $urandom_range(0, 4) == 0;
    bus.req_ack_i  = $urandom_range(0, 5) != 0;
    bus.err_clr    = $urandom_range(0, 15) == 0;
`ifdef NF_HU_PERF_CNT_EN
    bus.stall_cnt_clr = $urandom_range(0, 31) == 0;
`endif
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    pend        = 0;
    err_m       = 1'b0;
    cnt_m       = '0;
    rst         = 1'b1;
    apply_stimulus();
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    $display("[TB] forwarding");

    bus.wa_fwd = {AW'(5), AW'(5)};
    bus.we_fwd = 2'b11;
    bus.ra_exe = {AW'(0), AW'(5)};
    #1 cmp("fwd_nearest", 64'(bus.rd_bypass[SW-1:0]), 64'd1);
    tick();
    bus.we_fwd = 2'b10;
    #1 cmp("fwd_far", 64'(bus.rd_bypass[SW-1:0]), 64'd2);
    tick();

    bus.wa_fwd = {AW'(3), AW'(0)};
    bus.we_fwd = 2'b01;
    bus.ra_exe = {AW'(0), AW'(9)};
    bus.ra_id  = {AW'(0), AW'(4)};
    #1 cmp("fwd_x0_exe", 64'(bus.rd_bypass[SW +: SW]), 64'd0);
    cmp("fwd_x0_id", 64'(bus.cmp_bypass[1]), 64'd0);
    tick();

    $display("[TB] load-use");
    apply_stimulus();
    bus.we_rf_exe  = 1'b1;
    bus.rf_src_exe = 1'b1;
    bus.wa_exe     = AW'(7);
    bus.ra_id      = {AW'(2), AW'(7)};
    #1 cmp("lu_stall_if", 64'(bus.stall_if), 64'd1);
    cmp("lu_flush", 64'(bus.flush_exe), 64'd1);
    cmp("lu_stall_exe", 64'(bus.stall_exe), 64'd0);
    tick();
    bus.we_rf_exe = 1'b0;
    #1 cmp("lu_released", 64'(bus.stall_id), 64'd0);
    tick();

    $display("[TB] data-memory wait");
    bus.we_rf_exe  = 1'b1;
    bus.req_dm_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_ack_dm = (i == 3);
      #1 cmp("dm_busy_seq", 64'(bus.dm_busy), 64'(i > 0));
      cmp("dm_stall_wb", 64'(bus.stall_wb), 64'(i < 3));
      if (i < 3) cmp("dm_no_flush", 64'(bus.flush_exe), 64'd0);
      tick();
    end
    apply_stimulus();
    #1 cmp("dm_idle_after_ack", 64'(bus.dm_busy), 64'd0);
    tick();

    $display("[TB] timeout");
    bus.req_dm_mem = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 cmp("dm_err_seq", 64'(bus.dm_err), 64'(i >= 5));
      tick();
    end
    bus.req_dm_mem = 1'b0;
    tick();
    #1 cmp("dm_err_sticky", 64'(bus.dm_err), 64'd1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    #1 cmp("dm_err_cleared", 64'(bus.dm_err), 64'd0);
    bus.req_dm_mem = 1'b1;
    tick();
    tick();
    #1 cmp("dm_busy_before_rst", 64'(bus.dm_busy), 64'd1);
    rst = 1'b1;
    model_edge();
    #1 cmp("dm_busy_rst", 64'(bus.dm_busy), 64'd0);
    tick();
    rst = 1'b0;
    apply_stimulus();
    @(negedge clk);

`ifdef NF_HU_PERF_CNT_EN
    $display("[TB] stall counter");
    bus.stall_cnt_clr = 1'b1;
    tick();
    bus.stall_cnt_clr = 1'b0;
    bus.req_ack_i     = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    bus.req_ack_i = 1'b1;
    #1 cmp("stall_cnt_six", 64'(bus.stall_cnt), 64'd6);
    bus.stall_cnt_clr = 1'b1;
    tick();
    bus.stall_cnt_clr = 1'b0;
    #1 cmp("stall_cnt_clr", 64'(bus.stall_cnt), 64'd0);
    tick();
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      apply_random();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
